// File: rtl/pwm_sequencer.sv
// Step sequencer feeding one PWM generator: plays a table of {period, duty, repeat}
// entries, switching values only on period boundaries.
module pwm_sequencer #(
  parameter int C_COUNTER_WIDTH = 32,
  parameter int C_NUM_STEPS     = 8,
  parameter int C_REPEAT_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cfg_we,
  input  logic [$clog2(C_NUM_STEPS)-1:0]     cfg_addr,
  input  logic [C_COUNTER_WIDTH-1:0]         cfg_period,
  input  logic [C_COUNTER_WIDTH-1:0]         cfg_duty,
  input  logic [C_REPEAT_WIDTH-1:0]          cfg_repeat,
  input  logic [$clog2(C_NUM_STEPS):0]       num_steps,
  input  logic                               loop_en,
  input  logic                               run_req,
  input  logic                               halt_req,
  output logic                               pwm_start,
  output logic                               pwm_stop,
  output logic [C_COUNTER_WIDTH-1:0]         period_cnt,
  output logic [C_COUNTER_WIDTH-1:0]         duty_cnt,
  output logic [$clog2(C_NUM_STEPS)-1:0]     step_idx,
  output logic                               period_tick,
  output logic                               busy,
  output logic                               done,
  output logic [1:0]                         state_dbg
);

  localparam int IW = $clog2(C_NUM_STEPS);
  localparam logic [C_COUNTER_WIDTH-1:0] CYC_ONE  = 1;
  localparam logic [C_REPEAT_WIDTH-1:0]  REP_ONE  = 1;
  localparam logic [IW-1:0]              IDX_ONE  = 1;
  localparam logic [IW:0]                NUM_ONE  = 1;
  localparam logic [IW:0]                NUM_MAX  = (IW+1)'(C_NUM_STEPS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FINISH} state_t;

  // Control handshake: run_req and halt_req are single-cycle request pulses with no
  // back-pressure; a request not acceptable in the current state is dropped.
  state_t                     state_q;
  logic [C_COUNTER_WIDTH-1:0] tbl_period_q [C_NUM_STEPS];
  logic [C_COUNTER_WIDTH-1:0] tbl_duty_q   [C_NUM_STEPS];
  logic [C_REPEAT_WIDTH-1:0]  tbl_repeat_q [C_NUM_STEPS];

  logic [C_COUNTER_WIDTH-1:0] period_q, duty_q, cyc_q;
  logic [C_REPEAT_WIDTH-1:0]  rep_lim_q, rep_q;
  logic [IW-1:0]              idx_q;
  logic [IW:0]                num_q;
  logic                       loop_q, pwm_start_q, busy_q, done_q;

  logic [C_COUNTER_WIDTH-1:0] period_eff;
  logic [C_REPEAT_WIDTH-1:0]  rep_eff;
  logic                       at_tick, last_step;
  logic [IW-1:0]              ld_idx_d;

  assign period_eff = (period_q == '0) ? CYC_ONE : period_q;
  assign rep_eff    = (rep_lim_q == '0) ? REP_ONE : rep_lim_q;
  assign at_tick    = (state_q == S_RUN) && (cyc_q == period_eff);
  assign last_step  = ({1'b0, idx_q} == (num_q - NUM_ONE));
  assign ld_idx_d   = ((state_q == S_LOAD) || last_step) ? '0 : idx_q + IDX_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < C_NUM_STEPS; i++) begin
        tbl_period_q[i] <= '0;
        tbl_duty_q[i]   <= '0;
        tbl_repeat_q[i] <= '0;
      end
    end else if (cfg_we) begin
      tbl_period_q[cfg_addr] <= cfg_period;
      tbl_duty_q[cfg_addr]   <= cfg_duty;
      tbl_repeat_q[cfg_addr] <= cfg_repeat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      period_q    <= '0;
      duty_q      <= '0;
      cyc_q       <= '0;
      rep_lim_q   <= '0;
      rep_q       <= '0;
      idx_q       <= '0;
      num_q       <= '0;
      loop_q      <= 1'b0;
      pwm_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run_req && !halt_req) begin
            busy_q <= 1'b1;
            if (num_steps == '0) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_LOAD;
              num_q   <= (num_steps > NUM_MAX) ? NUM_MAX : num_steps;
              loop_q  <= loop_en;
            end
          end
        end
        S_LOAD, S_RUN: begin
          if (halt_req || (at_tick && (rep_q >= rep_eff) && last_step && !loop_q)) begin
            state_q     <= S_FINISH;
            pwm_start_q <= 1'b0;
            done_q      <= 1'b1;
          end else if (state_q == S_LOAD || at_tick) begin
            cyc_q <= CYC_ONE;
            if (state_q == S_RUN && rep_q < rep_eff) begin
              rep_q <= rep_q + REP_ONE;
            end else begin
              // Step load; old table contents are read if cfg_we targets this entry now.
              state_q     <= S_RUN;
              pwm_start_q <= 1'b1;
              idx_q       <= ld_idx_d;
              period_q    <= tbl_period_q[ld_idx_d];
              duty_q      <= tbl_duty_q[ld_idx_d];
              rep_lim_q   <= tbl_repeat_q[ld_idx_d];
              rep_q       <= REP_ONE;
            end
          end else begin
            cyc_q <= cyc_q + CYC_ONE;
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pwm_start   = pwm_start_q;
  assign pwm_stop    = ~pwm_start_q;
  assign period_cnt  = period_q;
  assign duty_cnt    = duty_q;
  assign step_idx    = idx_q;
  assign period_tick = at_tick;
  assign busy        = busy_q;
  assign done        = done_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Bench for pwm_sequencer: a trace-expanding reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pwm_sequencer;

  localparam int CW = 32;
  localparam int NS = 8;
  localparam int RW = 16;
  localparam int IW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_addr = '0;
  logic [CW-1:0] cfg_period = '0, cfg_duty = '0;
  logic [RW-1:0] cfg_repeat = '0;
  logic [IW:0]   num_steps = '0;
  logic          loop_en = 1'b0, run_req = 1'b0, halt_req = 1'b0;
  logic          pwm_start, pwm_stop, period_tick, busy, done;
  logic [CW-1:0] period_cnt, duty_cnt;
  logic [IW-1:0] step_idx;
  logic [1:0]    state_dbg;

  pwm_sequencer #(.C_COUNTER_WIDTH(CW), .C_NUM_STEPS(NS), .C_REPEAT_WIDTH(RW)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_repeat(cfg_repeat),
    .num_steps(num_steps), .loop_en(loop_en), .run_req(run_req), .halt_req(halt_req),
    .pwm_start(pwm_start), .pwm_stop(pwm_stop), .period_cnt(period_cnt),
    .duty_cnt(duty_cnt), .step_idx(step_idx), .period_tick(period_tick),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each step is expanded into its full list of cycles (tick flag per cycle) when it
  // is loaded; the model pops one cycle per clock.
  logic [CW-1:0] t_per [NS];
  logic [CW-1:0] t_duty[NS];
  logic [RW-1:0] t_rep [NS];
  logic [0:0]    exp_q[$];
  logic [CW-1:0] m_period, m_duty;
  int            m_idx, m_num;
  bit            m_loop, m_busy, m_done, m_pend, m_start, m_tick;

  task automatic expand(input int s);
    longint pe, re;
    pe = (t_per[s] == 0) ? 1 : t_per[s];
    re = (t_rep[s] == 0) ? 1 : t_rep[s];
    m_period = t_per[s];
    m_duty   = t_duty[s];
    m_idx    = s;
    exp_q.delete();
    for (longint r = 0; r < re; r++)
      for (longint c = 1; c <= pe; c++) exp_q.push_back((c == pe) ? 1'b1 : 1'b0);
  endtask

  task automatic pop_cycle();
    m_tick  = exp_q.pop_front();
    m_start = 1'b1;
  endtask

  task automatic model_finish();
    m_done  = 1'b1;
    m_start = 1'b0;
    m_pend  = 1'b0;
    exp_q.delete();
  endtask

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NS; i++) begin t_per[i] = 0; t_duty[i] = 0; t_rep[i] = 0; end
      exp_q.delete();
      m_period = 0; m_duty = 0; m_idx = 0; m_num = 0; m_loop = 0;
      m_busy = 0; m_done = 0; m_pend = 0; m_start = 0; m_tick = 0;
    end else begin
      m_tick = 1'b0;
      if (m_done) begin
        m_done = 1'b0;
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (run_req && !halt_req) begin
          m_busy = 1'b1;
          if (num_steps == 0) m_done = 1'b1;
          else begin m_pend = 1'b1; m_num = num_steps; m_loop = loop_en; end
        end
      end else if (halt_req) begin
        model_finish();
      end else if (m_pend) begin
        m_pend = 1'b0;
        expand(0);
        pop_cycle();
      end else if (exp_q.size() != 0) begin
        pop_cycle();
      end else if (m_idx == m_num - 1) begin
        if (m_loop) begin expand(0); pop_cycle(); end
        else model_finish();
      end else begin
        expand(m_idx + 1);
        pop_cycle();
      end
      if (cfg_we) begin
        t_per[cfg_addr] = cfg_period; t_duty[cfg_addr] = cfg_duty; t_rep[cfg_addr] = cfg_repeat;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("period_cnt", period_cnt, m_period);
      check("duty_cnt", duty_cnt, m_duty);
      check("step_idx", step_idx, m_idx[IW-1:0]);
      check("period_tick", period_tick, m_tick);
      check("pwm_start", pwm_start, m_start);
      check("pwm_stop", pwm_stop, !m_start);
      check("busy", busy, m_busy);
      check("done", done, m_done);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input int per, input int dty, input int rep);
    cfg_we = 1'b1; cfg_addr = a[IW-1:0]; cfg_period = per; cfg_duty = dty; cfg_repeat = rep[RW-1:0];
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic run(input int n, input bit lp);
    num_steps = n[IW:0]; loop_en = lp; run_req = 1'b1;
    cyc();
    run_req = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && busy; i++) cyc();
    check(name, busy, 0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1);
  end

  initial begin : main
    int n10, n6, ndone, done_at, idle_at, ticks1, n0, nt;
    cyc(); cmp_en = 1'b1; cyc(); reset = 1'b0;
    check("rst_period", period_cnt, 0);
    check("rst_stop", pwm_stop, 1);
    check("rst_busy", busy, 0);

    // 1: two steps, no loop
    wr(0, 10, 4, 2); wr(1, 6, 2, 3);
    run(2, 0);
    check("t1_load_start", pwm_start, 0);
    check("t1_load_busy", busy, 1);
    cyc();
    check("t1_run_start", pwm_start, 1);
    check("t1_run_period", period_cnt, 10);
    check("t1_run_duty", duty_cnt, 4);
    n10 = 1; n6 = 0; ndone = 0; done_at = -1; idle_at = -1;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (pwm_start && period_cnt == 10) n10++;
      if (pwm_start && period_cnt == 6) n6++;
      if (done) begin ndone++; done_at = i; end
      if (!busy) begin idle_at = i; break; end
    end
    check("t1_cycles_p10", n10, 20);
    check("t1_cycles_p6", n6, 18);
    check("t1_done_pulses", ndone, 1);
    check("t1_idle_after_done", idle_at - done_at, 1);

    // 2: loop, then halt
    run(2, 1);
    ticks1 = 0;
    for (int i = 0; i < 200 && ticks1 < 3; i++) begin
      cyc();
      if (period_tick && step_idx == 1) ticks1++;
    end
    check("t2_e1_ticks", ticks1, 3);
    cyc();
    check("t2_wrap_idx", step_idx, 0);
    check("t2_wrap_period", period_cnt, 10);
    repeat (7) cyc();
    halt_req = 1'b1; cyc(); halt_req = 1'b0;
    check("t2_halt_start", pwm_start, 0);
    check("t2_halt_done", done, 1);
    cyc();
    check("t2_halt_idle", busy, 0);

    // 3: zero period/repeat act as 1
    wr(0, 0, 7, 0); wr(1, 3, 1, 1);
    run(2, 0);
    n0 = 0; nt = 0;
    for (int i = 0; i < 50 && busy; i++) begin
      cyc();
      if (pwm_start && step_idx == 0) n0++;
      if (period_tick) nt++;
    end
    check("t3_step0_cycles", n0, 1);
    check("t3_ticks", nt, 2);

    // 4: empty sequence, then run_req while busy
    run(0, 0);
    check("t4_done", done, 1);
    check("t4_start", pwm_start, 0);
    cyc();
    check("t4_idle", busy, 0);
    wr(0, 10, 4, 2); wr(1, 6, 2, 3);
    run(2, 0);
    repeat (5) cyc();
    run(1, 1);
    check("t4_ignored_idx", step_idx, 0);
    check("t4_ignored_period", period_cnt, 10);
    wait_idle("t4_finish", 100);

    // 5: rewrite e1 during step 0; same-cycle write at the boundary
    wr(0, 4, 1, 2); wr(1, 5, 2, 1);
    run(2, 0);
    cyc(); cyc();
    wr(1, 7, 3, 1);
    for (int i = 0; i < 50 && step_idx != 1; i++) cyc();
    check("t5_new_period", period_cnt, 7);
    check("t5_new_duty", duty_cnt, 3);
    wait_idle("t5a_finish", 50);
    wr(0, 4, 1, 1); wr(1, 5, 2, 1);
    run(2, 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (period_tick && step_idx == 0) break;
    end
    cfg_we = 1'b1; cfg_addr = 1; cfg_period = 9; cfg_duty = 9; cfg_repeat = 1;
    @(posedge clk); #1; cfg_we = 1'b0;
    check("t5_old_period", period_cnt, 5);
    check("t5_old_duty", duty_cnt, 2);
    check("t5_old_idx", step_idx, 1);
    wait_idle("t5b_finish", 50);

    // 6: reset mid-run clears the table; halt+run in idle is ignored
    wr(0, 10, 4, 2);
    run(1, 1);
    repeat (6) cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    check("t6_rst_start", pwm_start, 0);
    check("t6_rst_period", period_cnt, 0);
    check("t6_rst_duty", duty_cnt, 0);
    check("t6_rst_busy", busy, 0);
    run(1, 0); cyc();
    check("t6_tbl_period", period_cnt, 0);
    check("t6_tbl_tick", period_tick, 1);
    wait_idle("t6_finish", 20);
    num_steps = 1; run_req = 1'b1; halt_req = 1'b1;
    cyc();
    run_req = 1'b0; halt_req = 1'b0;
    check("t6_both_busy", busy, 0);
    cyc();
    check("t6_both_start", pwm_start, 0);

    repeat (3) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
